// File: rtl/conv1_img_read.sv
// Conv1 upstream sequencer: walks every KxK window of the IMG_W x IMG_W image with incremental addressing.
// Optional macro CONV1_RD_WT_ADDR_EN adds the wt_addr port for lockstep kernel-weight reads.
module conv1_img_read #(
    parameter int IMG_W  = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    output logic [ADDR_W-1:0] img_addr,
`ifdef CONV1_RD_WT_ADDR_EN
    output logic [4:0]        wt_addr,
`endif
    output logic              addr_valid,
    output logic              data_valid_q,
    output logic              win_first_q,
    output logic              win_last_q,
    output logic              busy,
    output logic              done
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int KW    = $clog2(K);
    localparam int OW    = $clog2(OUT_W);
    localparam int DW    = $clog2(RD_LAT + 1);

    localparam logic [KW-1:0]     K_LAST     = KW'(K - 1);
    localparam logic [OW-1:0]     OUT_LAST   = OW'(OUT_W - 1);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
    // From the last window of a row to the first of the next: IMG_W - OUT_W + 1 = K
    localparam logic [ADDR_W-1:0] ROW_JUMP   = ADDR_W'(IMG_W - OUT_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [KW-1:0]     kc, kr;
    logic [OW-1:0]     oc, orow;
    logic [ADDR_W-1:0] win_base, row_base;
    logic [DW-1:0]     drain_cnt;
    logic              win_end, win_first, win_last;
    logic [RD_LAT-1:0] valid_sr, first_sr, last_sr;

    assign addr_valid   = (state == RUN) && enable;
    assign win_end      = (kr == K_LAST) && (kc == K_LAST);
    assign win_first    = addr_valid && (kr == '0) && (kc == '0);
    assign win_last     = addr_valid && win_end;
    assign img_addr     = row_base + ADDR_W'(kc);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign data_valid_q = valid_sr[RD_LAT-1];
    assign win_first_q  = first_sr[RD_LAT-1];
    assign win_last_q   = last_sr[RD_LAT-1];

    // row_base tracks the current kernel row start; win_base tracks the window origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            kc        <= '0;
            kr        <= '0;
            oc        <= '0;
            orow      <= '0;
            win_base  <= '0;
            row_base  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        kc       <= '0;
                        kr       <= '0;
                        oc       <= '0;
                        orow     <= '0;
                        win_base <= '0;
                        row_base <= '0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (win_end) begin
                            kc <= '0;
                            kr <= '0;
                            if (oc == OUT_LAST) begin
                                oc <= '0;
                                if (orow == OUT_LAST) begin
                                    orow      <= '0;
                                    win_base  <= '0;
                                    row_base  <= '0;
                                    drain_cnt <= '0;
                                    state     <= DRAIN;
                                end else begin
                                    orow     <= orow + OW'(1);
                                    win_base <= win_base + ROW_JUMP;
                                    row_base <= win_base + ROW_JUMP;
                                end
                            end else begin
                                oc       <= oc + OW'(1);
                                win_base <= win_base + ADDR_W'(1);
                                row_base <= win_base + ADDR_W'(1);
                            end
                        end else if (kc == K_LAST) begin
                            kc       <= '0;
                            kr       <= kr + KW'(1);
                            row_base <= row_base + ROW_STEP;
                        end else begin
                            kc <= kc + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Markers ride alongside the memory read latency so they line up with read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_sr <= '0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= addr_valid;
            first_sr[0] <= win_first;
            last_sr[0]  <= win_last;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                first_sr[i] <= first_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

`ifdef CONV1_RD_WT_ADDR_EN
    logic [4:0] wt_cnt;

    assign wt_addr = wt_cnt;

    // Tap counter equals kr*K+kc without a multiplier; issued in the same cycle as img_addr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wt_cnt <= '0;
        end else if (((state == IDLE) || (state == DONE)) && start) begin
            wt_cnt <= '0;
        end else if (addr_valid) begin
            wt_cnt <= win_end ? 5'd0 : wt_cnt + 5'd1;
        end
    end
`endif

endmodule
